wb_writer: RTL and testbench

Writeback-side writer for the 8 x 32 register file. Accepts results from the ALU and load paths over a valid/ready handshake, queues them in a small FIFO, and drives the register file's write port (`sto`, `waddr`, `dataIn`) at one write per cycle. Also exposes a youngest-match forwarding lookup for the two read addresses, so the decode stage can bypass writes that are still in flight.

---
 rtl/wb_writer.sv | 130 +++++++++++++
 tb/tb_wb_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// Writeback writer: queues ALU/load results in a small FIFO and drains one
// register-file write per cycle, with youngest-match forwarding lookups.
module wb_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              in_ready,
  output logic              sto,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] fwd1,
  output logic [DATA_W-1:0] fwd2,
  output logic [ADDR_W:0]   count,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = ADDR_W + 1;
  // Two free slots are required so a dual push can never overflow.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, alu_slot_s;
  logic [CW-1:0]     count_q, count_d;
  logic              sto_q, sto_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              ready_s, push_mem_s, push_alu_s, pop_s;
  logic [DATA_W:0]   look1_s, look2_s;

  // Returns {hit, data}: output register is the weakest match, then FIFO oldest to newest.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] ra);
    logic [DATA_W:0] res;
    logic [PW-1:0]   idx;
    logic            match;
    res = (sto_q && (waddr_q == ra)) ? {1'b1, data_in_q} : {(DATA_W+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx   = rd_ptr_q + PW'(i);
      match = (CW'(i) < count_q) && (addr_q[idx] == ra);
      res   = match ? {1'b1, data_q[idx]} : res;
    end
    return res;
  endfunction

  // Handshake decode and FIFO/output-stage next state.
  always_comb begin
    ready_s    = (count_q <= READY_MAX);
    push_mem_s = mem_valid & ready_s;
    push_alu_s = alu_valid & ready_s;
    pop_s      = (count_q != {CW{1'b0}});
    data_d     = data_q;
    addr_d     = addr_q;
    alu_slot_s = wr_ptr_q + PW'(push_mem_s);
    data_d[wr_ptr_q]   = push_mem_s ? mem_data : data_q[wr_ptr_q];
    addr_d[wr_ptr_q]   = push_mem_s ? mem_addr : addr_q[wr_ptr_q];
    data_d[alu_slot_s] = push_alu_s ? alu_data : data_d[alu_slot_s];
    addr_d[alu_slot_s] = push_alu_s ? alu_addr : addr_d[alu_slot_s];
    wr_ptr_d = wr_ptr_q + PW'(push_mem_s) + PW'(push_alu_s);
    rd_ptr_d = rd_ptr_q + PW'(pop_s);
    count_d  = count_q + CW'(push_mem_s) + CW'(push_alu_s) - CW'(pop_s);
    if (pop_s) begin
      sto_d     = 1'b1;
      waddr_d   = addr_q[rd_ptr_q];
      data_in_d = data_q[rd_ptr_q];
    end else begin
      sto_d     = 1'b0;
      waddr_d   = waddr_q;
      data_in_d = data_in_q;
    end
  end

  // Forwarding lookups for both read ports.
  always_comb begin
    look1_s = lookup(raddr1);
    look2_s = lookup(raddr2);
  end

  // State registers; reset discards all pending writes and drops sto at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {DATA_W{1'b0}};
        addr_q[i] <= {ADDR_W{1'b0}};
      end
      rd_ptr_q  <= {PW{1'b0}};
      wr_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      sto_q     <= 1'b0;
      waddr_q   <= {ADDR_W{1'b0}};
      data_in_q <= {DATA_W{1'b0}};
    end else begin
      data_q    <= data_d;
      addr_q    <= addr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      sto_q     <= sto_d;
      waddr_q   <= waddr_d;
      data_in_q <= data_in_d;
    end
  end

  assign in_ready = ready_s;
  assign sto      = sto_q;
  assign waddr    = waddr_q;
  assign dataIn   = data_in_q;
  assign count    = count_q;
  assign empty    = (count_q == {CW{1'b0}}) && !sto_q;
  assign hit1     = look1_s[DATA_W];
  assign fwd1     = look1_s[DATA_W-1:0];
  assign hit2     = look2_s[DATA_W];
  assign fwd2     = look2_s[DATA_W-1:0];

endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: directed vector table plus randomized traffic checked
// against a queue-based model of pending register writes.
module tb_wb_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [2:0]  alu_addr = 3'd0, mem_addr = 3'd0, raddr1 = 3'd0, raddr2 = 3'd0;
  logic [31:0] alu_data = 32'd0, mem_data = 32'd0;
  logic        in_ready, sto, hit1, hit2, empty;
  logic [2:0]  waddr;
  logic [31:0] dataIn, fwd1, fwd2;
  logic [3:0]  count;

  wb_writer #(.DATA_W(32), .ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .in_ready(in_ready), .sto(sto), .waddr(waddr), .dataIn(dataIn),
    .raddr1(raddr1), .raddr2(raddr2), .hit1(hit1), .hit2(hit2),
    .fwd1(fwd1), .fwd2(fwd2), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [2:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic        m_sto = 1'b0;
  logic [2:0]  m_waddr = 3'd0;
  logic [31:0] m_din = 32'd0;
  bit          collect_en = 1'b0;
  logic [31:0] obs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] m_look(input logic [2:0] ra);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == ra) return {1'b1, mq[i].d};
    if (m_sto && m_waddr == ra) return {1'b1, m_din};
    return 33'd0;
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_sto = 1'b0; m_waddr = 3'd0; m_din = 32'd0;
  endfunction

  // One rising edge: pop head into the write port, then push mem before alu.
  function automatic void model_edge();
    bit   rdy;
    ent_t e;
    rdy = (4 - mq.size()) >= 2;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_sto = 1'b1; m_waddr = e.a; m_din = e.d;
    end else m_sto = 1'b0;
    if (rdy && mem_valid) mq.push_back({mem_addr, mem_data});
    if (rdy && alu_valid) mq.push_back({alu_addr, alu_data});
  endfunction

  task automatic check_model();
    logic [32:0] l1, l2;
    l1 = m_look(raddr1);
    l2 = m_look(raddr2);
    chk("sto", 32'(sto), 32'(m_sto));
    chk("waddr", 32'(waddr), 32'(m_waddr));
    chk("dataIn", dataIn, m_din);
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), (mq.size() <= 2) ? 32'd1 : 32'd0);
    chk("empty", 32'(empty), (mq.size() == 0 && !m_sto) ? 32'd1 : 32'd0);
    chk("hit1", 32'(hit1), 32'(l1[32]));
    chk("fwd1", fwd1, l1[31:0]);
    chk("hit2", 32'(hit2), 32'(l2[32]));
    chk("fwd2", fwd2, l2[31:0]);
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [2:0] ma, input logic [31:0] md,
                       input logic [2:0] r1, input logic [2:0] r2);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    raddr1 = r1; raddr2 = r2;
  endtask

  task automatic finish_cycle();
    check_model();
    if (collect_en && sto) obs.push_back(dataIn);
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle(input logic av, input logic [2:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [2:0] ma, input logic [31:0] md,
                       input logic [2:0] r1, input logic [2:0] r2);
    drive(av, aa, ad, mv, ma, md, r1, r2);
    #1;
    finish_cycle();
  endtask

  typedef struct {
    logic av; logic [2:0] aa; logic [31:0] ad;
    logic mv; logic [2:0] ma; logic [31:0] md;
    logic [2:0] r1; logic [2:0] r2;
    logic sto; logic [2:0] wa; logic [31:0] din; logic [3:0] cnt; logic rdy;
    logic h1; logic [31:0] f1; logic h2; logic [31:0] f2; logic emp;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic        pa, pm, rdy_m;
    logic [2:0]  aa, ma;
    logic [31:0] ad, md, nxt;

    // Expected outputs are those seen before the edge that applies the row.
    vt[0]  = '{1'b1,3'd2,32'hABCD1234, 1'b0,3'd0,32'h0,  3'd2,3'd5, 1'b0,3'd0,32'h0,        4'd0,1'b1, 1'b0,32'h0,        1'b0,32'h0,  1'b1};
    vt[1]  = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd2,3'd5, 1'b0,3'd0,32'h0,        4'd1,1'b1, 1'b1,32'hABCD1234, 1'b0,32'h0,  1'b0};
    vt[2]  = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd2,3'd5, 1'b1,3'd2,32'hABCD1234, 4'd0,1'b1, 1'b1,32'hABCD1234, 1'b0,32'h0,  1'b0};
    vt[3]  = '{1'b1,3'd5,32'h22,       1'b1,3'd5,32'h11, 3'd2,3'd5, 1'b0,3'd2,32'hABCD1234, 4'd0,1'b1, 1'b0,32'h0,        1'b0,32'h0,  1'b1};
    vt[4]  = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd2,3'd5, 1'b0,3'd2,32'hABCD1234, 4'd2,1'b1, 1'b0,32'h0,        1'b1,32'h22, 1'b0};
    vt[5]  = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd2,3'd5, 1'b1,3'd5,32'h11,       4'd1,1'b1, 1'b0,32'h0,        1'b1,32'h22, 1'b0};
    vt[6]  = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd2,3'd5, 1'b1,3'd5,32'h22,       4'd0,1'b1, 1'b0,32'h0,        1'b1,32'h22, 1'b0};
    vt[7]  = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd2,3'd5, 1'b0,3'd5,32'h22,       4'd0,1'b1, 1'b0,32'h0,        1'b0,32'h0,  1'b1};
    vt[8]  = '{1'b1,3'd3,32'h9,        1'b0,3'd0,32'h0,  3'd3,3'd0, 1'b0,3'd5,32'h22,       4'd0,1'b1, 1'b0,32'h0,        1'b0,32'h0,  1'b1};
    vt[9]  = '{1'b1,3'd3,32'hB,        1'b1,3'd3,32'hA,  3'd3,3'd0, 1'b0,3'd5,32'h22,       4'd1,1'b1, 1'b1,32'h9,        1'b0,32'h0,  1'b0};
    vt[10] = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd3,3'd0, 1'b1,3'd3,32'h9,        4'd2,1'b1, 1'b1,32'hB,        1'b0,32'h0,  1'b0};
    vt[11] = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd3,3'd0, 1'b1,3'd3,32'hA,        4'd1,1'b1, 1'b1,32'hB,        1'b0,32'h0,  1'b0};
    vt[12] = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd3,3'd0, 1'b1,3'd3,32'hB,        4'd0,1'b1, 1'b1,32'hB,        1'b0,32'h0,  1'b0};
    vt[13] = '{1'b0,3'd0,32'h0,        1'b0,3'd0,32'h0,  3'd3,3'd0, 1'b0,3'd3,32'hB,        4'd0,1'b1, 1'b0,32'h0,        1'b0,32'h0,  1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_clear();

    // Directed table: latency, dual push ordering, forward priority.
    for (int k = 0; k < 14; k++) begin
      drive(vt[k].av, vt[k].aa, vt[k].ad, vt[k].mv, vt[k].ma, vt[k].md, vt[k].r1, vt[k].r2);
      #1;
      chk($sformatf("v%0d_sto", k), 32'(sto), 32'(vt[k].sto));
      chk($sformatf("v%0d_waddr", k), 32'(waddr), 32'(vt[k].wa));
      chk($sformatf("v%0d_dataIn", k), dataIn, vt[k].din);
      chk($sformatf("v%0d_count", k), 32'(count), 32'(vt[k].cnt));
      chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(vt[k].rdy));
      chk($sformatf("v%0d_hit1", k), 32'(hit1), 32'(vt[k].h1));
      chk($sformatf("v%0d_fwd1", k), fwd1, vt[k].f1);
      chk($sformatf("v%0d_hit2", k), 32'(hit2), 32'(vt[k].h2));
      chk($sformatf("v%0d_fwd2", k), fwd2, vt[k].f2);
      chk($sformatf("v%0d_empty", k), 32'(empty), 32'(vt[k].emp));
      finish_cycle();
    end

    // Fill: both sources always valid, each holds its data until accepted.
    nxt = 32'd100;
    for (int k = 0; k < 12; k++) begin
      rdy_m = (mq.size() <= 2);
      cycle(1'b1, 3'(k + 1), nxt + 32'd1, 1'b1, 3'(k), nxt, 3'(k), 3'(k + 1));
      chk("fill_count_max", (count <= 4'd4) ? 32'd1 : 32'd0, 32'd1);
      if (rdy_m) nxt = nxt + 32'd2;
    end
    repeat (6) cycle(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd2);

    // Pointer wrap: 20 back-to-back single pushes, data = index.
    collect_en = 1'b1;
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 3'(i), 32'(i), 1'b0, 3'd0, 32'd0, 3'(i), 3'(i + 7));
    cycle(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 3'd3, 3'd4);
    cycle(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 3'd3, 3'd4);
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 3'd3, 3'd4);
    #1;
    chk("wrap_empty", 32'(empty), 32'd1);
    finish_cycle();
    collect_en = 1'b0;
    chk("wrap_n", 32'(obs.size()), 32'd20);
    for (int i = 0; i < obs.size() && i < 20; i++)
      chk($sformatf("wrap_data%0d", i), obs[i], 32'(i));

    // Mid-operation reset with three writes pending.
    cycle(1'b1, 3'd2, 32'h2222, 1'b1, 3'd1, 32'h1111, 3'd1, 3'd2);
    cycle(1'b1, 3'd4, 32'h4444, 1'b0, 3'd0, 32'd0, 3'd1, 3'd2);
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 3'd2, 3'd4);
    #1;
    chk("pre_rst_sto", 32'(sto), 32'd1);
    chk("pre_rst_count", 32'(count), 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("rst_sto", 32'(sto), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_hit1", 32'(hit1), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 3'd2, 3'd4);
      #1;
      chk("post_rst_sto", 32'(sto), 32'd0);
      chk("post_rst_hit2", 32'(hit2), 32'd0);
      finish_cycle();
    end

    // Randomized traffic; a refused source keeps its entry on the next cycle.
    pa = 1'b0; pm = 1'b0; aa = 3'd0; ma = 3'd0; ad = 32'd0; md = 32'd0;
    for (int k = 0; k < 400; k++) begin
      if (!pa) begin
        pa = 1'($urandom_range(0, 1)); aa = 3'($urandom_range(0, 7)); ad = $urandom;
      end
      if (!pm) begin
        pm = 1'($urandom_range(0, 1)); ma = 3'($urandom_range(0, 7)); md = $urandom;
      end
      rdy_m = (mq.size() <= 2);
      cycle(pa, aa, ad, pm, ma, md, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if (rdy_m) begin
        pa = 1'b0; pm = 1'b0;
      end
    end
    repeat (6) cycle(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
